// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 decryption core: key schedule stored once, then one inverse round per clock.
// S-boxes are computed arithmetically (GF(2^8) inverse plus affine map) rather than tabulated.
package aes_inv_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] imc_coef(input logic [1:0] k);
    case (k)
      2'd0:    return 8'h0e;
      2'd1:    return 8'h0b;
      2'd2:    return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// One state column: InvSubBytes + AddRoundKey, then InvMixColumns for the middle rounds
module aes_inv_col (
  input  logic [31:0] col,
  input  logic [31:0] rk_w,
  output logic [31:0] fin,
  output logic [31:0] mix
);
  import aes_inv_pkg::*;
  logic [7:0] a [4];
  logic [7:0] b [4];

  always_comb begin
    for (int i = 0; i < 4; i++) a[i] = sbox_inv(col[31-8*i -: 8]) ^ rk_w[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'h00;
      for (int j = 0; j < 4; j++) b[i] = b[i] ^ gf_mul(imc_coef(2'(j - i)), a[j]);
    end
  end

  assign fin = {a[0], a[1], a[2], a[3]};
  assign mix = {b[0], b[1], b[2], b[3]};
endmodule

module aes_inv_cipher_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done,
  output logic         key_rdy,
  output logic         busy,
  output logic [3:0]   dcnt
);
  import aes_inv_pkg::*;

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;
  state_t state, state_nxt;

  logic [127:0] rk [NR+1];
  logic [127:0] st, shr, rk_cur, kprev, fin_blk, mix_blk;
  logic [31:0]  kt, n0, n1, n2, n3;
  logic         kld_acc, ld_acc;

  assign kld_acc = (state == IDLE) && kld;
  assign ld_acc  = (state == IDLE) && !kld && ld && key_rdy;
  assign busy    = (state != IDLE);
  assign rk_cur  = rk[dcnt];
  assign kprev   = rk[dcnt - 4'd1];

  // Forward key schedule step; dcnt doubles as the round index for Rcon
  assign kt = {sbox_fwd(kprev[23:16]), sbox_fwd(kprev[15:8]), sbox_fwd(kprev[7:0]),
               sbox_fwd(kprev[31:24])} ^ {rcon(dcnt), 24'h0};
  assign n0 = kprev[127:96] ^ kt;
  assign n1 = kprev[95:64]  ^ n0;
  assign n2 = kprev[63:32]  ^ n1;
  assign n3 = kprev[31:0]   ^ n2;

  // InvShiftRows: row r rotates right by r columns
  always_comb begin
    shr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_inv_col u_col (
      .col  (shr[127-32*c -: 32]),
      .rk_w (rk_cur[127-32*c -: 32]),
      .fin  (fin_blk[127-32*c -: 32]),
      .mix  (mix_blk[127-32*c -: 32])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (kld_acc) state_nxt = KEXP;
            else if (ld_acc) state_nxt = DEC;
      KEXP: if (dcnt == 4'(NR)) state_nxt = IDLE;
      DEC:  if (dcnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath storage carries no reset; its contents are meaningless until reloaded
  always_ff @(posedge clk) begin
    if (kld_acc) rk[0] <= key;
    if (state == KEXP) rk[dcnt] <= {n0, n1, n2, n3};
    if (ld_acc) st <= text_in ^ rk[NR];
    else if (state == DEC) st <= mix_blk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      text_out <= '0;
      done     <= 1'b0;
      key_rdy  <= 1'b0;
      dcnt     <= '0;
    end else begin
      done <= 1'b0;
      if (kld_acc) begin
        key_rdy <= 1'b0;
        dcnt    <= 4'd1;
      end else if (ld_acc) begin
        dcnt <= 4'(NR - 1);
      end else if (state == KEXP) begin
        if (dcnt == 4'(NR)) begin
          key_rdy <= 1'b1;
          dcnt    <= '0;
        end else begin
          dcnt <= dcnt + 4'd1;
        end
      end else if (state == DEC) begin
        if (dcnt == 4'd0) begin
          text_out <= fin_blk;
          done     <= 1'b1;
        end else begin
          dcnt <= dcnt - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Scoreboard bench for aes_inv_cipher_core: FIPS vectors, guards, reset abort and random
// round trips through a forward AES model built from a generated S-box.
module tb_aes_inv_cipher_core;
  logic         clk = 1'b0, rst = 1'b1, kld = 1'b0, ld = 1'b0;
  logic [127:0] key = '0, text_in = '0;
  logic [127:0] text_out;
  logic         done, key_rdy, busy;
  logic [3:0]   dcnt;

  aes_inv_cipher_core #(.NR(10)) dut (
    .clk(clk), .rst(rst), .kld(kld), .key(key), .ld(ld), .text_in(text_in),
    .text_out(text_out), .done(done), .key_rdy(key_rdy), .busy(busy), .dcnt(dcnt)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  int tests = 0, fails = 0, done_cnt = 0, cyc = 0;
  int done_cyc = 0, prev_done_cyc = 0, ld_cyc = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb [256];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse is matched against the oldest expected plaintext
  always @(negedge clk) begin
    if (done) begin
      logic [127:0] e;
      done_cnt++;
      prev_done_cyc = done_cyc;
      done_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got text_out=%h, required no done", text_out);
      end else begin
        e = exp_q.pop_front();
        if (text_out !== e) begin
          fails++;
          $display("FAIL plaintext: got %h, required %h", text_out, e);
        end
      end
    end
  end

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // p walks powers of 3, q walks their inverses; affine-map q into sb[p]
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*((c+rw)%4)+rw];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    kld = 1'b1;
    key = k;
    tick();
    kld = 1'b0;
    for (int n = 0; n < 20 && !key_rdy; n++) tick();
    chk("key_rdy_after_kexp", 128'(key_rdy), 128'd1);
  endtask

  task automatic issue_ld(input logic [127:0] ct, input logic [127:0] pt, input bit push);
    ld = 1'b1;
    text_in = ct;
    if (push) exp_q.push_back(pt);
    tick();
    ld = 1'b0;
    ld_cyc = cyc;
  endtask

  task automatic wait_done(input int target, input string nm);
    for (int n = 0; n < 40 && done_cnt < target; n++) tick();
    chk(nm, 128'(done_cnt), 128'(target));
  endtask

  initial begin
    int c0, ld1;
    logic [127:0] rk_k, rk_p;
    build_sbox();

    // Reset state
    repeat (2) tick();
    chk("rst_text_out", text_out, 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_key_rdy", 128'(key_rdy), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_dcnt", 128'(dcnt), 128'd0);
    rst = 1'b0;
    tick();

    // ld with no key loaded
    c0 = done_cnt;
    issue_ld(C1, '0, 1'b0);
    repeat (20) tick();
    chk("ld_without_key", 128'(done_cnt), 128'(c0));

    // FIPS C.1 with latency
    load_key(K1);
    issue_ld(C1, P1, 1'b1);
    wait_done(c0 + 1, "t1_done");
    chk("t1_latency", 128'(done_cyc - ld_cyc), 128'd10);

    // FIPS B
    load_key(K2);
    issue_ld(C2, P2, 1'b1);
    wait_done(c0 + 2, "t2_done");

    // Back-to-back: second ld in the done cycle
    load_key(K1);
    issue_ld(C1, P1, 1'b1);
    ld1 = ld_cyc;
    for (int n = 0; n < 20 && !done; n++) tick();
    issue_ld(C1, P1, 1'b1);
    chk("b2b_ld_spacing", 128'(ld_cyc - ld1), 128'd11);
    wait_done(c0 + 4, "b2b_done");
    chk("b2b_done_spacing", 128'(done_cyc - prev_done_cyc), 128'd11);
    chk("b2b_latency", 128'(done_cyc - ld_cyc), 128'd10);

    // kld and ld during DEC are ignored
    issue_ld(C1, P1, 1'b1);
    repeat (4) tick();
    ld = 1'b1; kld = 1'b1; key = K2; text_in = C2;
    tick();
    ld = 1'b0; kld = 1'b0;
    wait_done(c0 + 5, "busy_guard_done");
    chk("busy_guard_key_rdy", 128'(key_rdy), 128'd1);
    issue_ld(C1, P1, 1'b1);
    wait_done(c0 + 6, "busy_guard_key_kept");

    // kld and ld together in IDLE: kld wins
    c0 = done_cnt;
    kld = 1'b1; ld = 1'b1; key = K2; text_in = C2;
    tick();
    kld = 1'b0; ld = 1'b0;
    chk("kld_ld_key_rdy", 128'(key_rdy), 128'd0);
    chk("kld_ld_busy", 128'(busy), 128'd1);
    for (int n = 0; n < 20 && !key_rdy; n++) tick();
    repeat (12) tick();
    chk("kld_ld_no_done", 128'(done_cnt), 128'(c0));
    issue_ld(C2, P2, 1'b1);
    wait_done(c0 + 1, "kld_ld_new_key");

    // Reset at D4 aborts decryption and drops the key
    load_key(K1);
    issue_ld(C1, '0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("abort_text_out", text_out, 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_key_rdy", 128'(key_rdy), 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_dcnt", 128'(dcnt), 128'd0);
    rst = 1'b0;
    c0 = done_cnt;
    repeat (12) tick();
    chk("abort_no_done", 128'(done_cnt), 128'(c0));
    load_key(K2);
    issue_ld(C2, P2, 1'b1);
    wait_done(c0 + 1, "abort_reload");

    // Random round trips through the forward model
    for (int i = 0; i < 1000; i++) begin
      rk_k = {$urandom, $urandom, $urandom, $urandom};
      rk_p = {$urandom, $urandom, $urandom, $urandom};
      c0 = done_cnt;
      load_key(rk_k);
      issue_ld(enc(rk_k, rk_p), rk_p, 1'b1);
      wait_done(c0 + 1, "rand_done");
    end

    repeat (3) tick();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
